// File: rtl/spike_input_buffer.sv
// Spike ingress buffer: resolves {dest, src} spike packets against a CSR
// upstream-connection table and sets one bit in a double-buffered bitmap.
// Each timestep boundary swaps the banks, so the compute unit always reads
// a stable bitmap for the previous timestep.
module spike_input_buffer #(
    parameter int NEURON_ADDR_W = 10,
    parameter int NUM_NEURONS   = 10,
    parameter int MAX_CONN      = 30,
    parameter int CONN_IDX_W    = 5
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       spike_valid,
    output logic                       spike_ready,
    input  logic [2*NEURON_ADDR_W-1:0] spike_packet,
    input  logic                       cfg_we,
    input  logic                       cfg_sel,
    input  logic [CONN_IDX_W:0]        cfg_addr,
    input  logic [NEURON_ADDR_W-1:0]   cfg_wdata,
    input  logic                       timestep,
    input  logic [CONN_IDX_W-1:0]      rd_idx,
    output logic                       rd_spike,
    output logic                       busy,
    output logic [15:0]                drop_count
);

    localparam int PTR_W     = CONN_IDX_W + 1;
    localparam int ROW_IDX_W = $clog2(NUM_NEURONS + 1);

    typedef enum logic [1:0] {IDLE, FETCH, SEARCH} state_t;

    state_t                   state, state_next;
    logic [PTR_W-1:0]         row_ptr   [NUM_NEURONS+1];
    logic [NEURON_ADDR_W-1:0] src_table [MAX_CONN];
    logic [1:0][MAX_CONN-1:0] bank;
    logic                     wr_sel;
    logic                     swap_pending;
    logic [NEURON_ADDR_W-1:0] dest_q, src_q;
    logic [PTR_W-1:0]         idx_q, end_q;

    logic                     accept, do_swap, cfg_ok;
    logic                     dest_ok, in_range, hit, last;
    logic [ROW_IDX_W-1:0]     dest_row, dest_row_nx;
    logic [PTR_W-1:0]         row_start, row_end;
    logic [CONN_IDX_W-1:0]    conn_idx;
    logic                     drop_inc, set_bit;

    // A pending swap blocks new packets; the swap itself uses the idle cycle.
    assign spike_ready = !RESET && (state == IDLE) && !swap_pending;
    assign busy        = (state != IDLE) || swap_pending;
    assign accept      = spike_valid && spike_ready;
    assign do_swap     = (state == IDLE) && swap_pending;
    assign cfg_ok      = cfg_we && !busy;

    assign dest_ok     = int'(dest_q) < NUM_NEURONS;
    assign dest_row    = ROW_IDX_W'(dest_q);
    assign dest_row_nx = dest_row + ROW_IDX_W'(1);
    assign conn_idx    = idx_q[CONN_IDX_W-1:0];
    assign in_range    = int'(idx_q) < MAX_CONN;
    assign last        = (idx_q == end_q - PTR_W'(1));

    // Row-pointer lookup for the latched destination; invalid rows read as empty.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        row_start = '0;
        row_end   = '0;
        if (dest_ok) begin
            row_start = row_ptr[dest_row];
            row_end   = row_ptr[dest_row_nx];
        end
    end

    // Source-table compare for the current search index.
    always_comb begin
        hit = 1'b0;
        if (in_range) begin
            hit = (src_table[conn_idx] == src_q);
        end
    end

    // Next-state and per-cycle action decode.
    always_comb begin
        state_next = state;
        drop_inc   = 1'b0;
        set_bit    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_next = FETCH;
            end
            FETCH: begin
                if (!dest_ok || row_start >= row_end) begin
                    drop_inc   = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = SEARCH;
                end
            end
            SEARCH: begin
                if (hit) begin
                    set_bit    = 1'b1;
                    state_next = IDLE;
                end else if (last) begin
                    drop_inc   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register plus packet latch and search index.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= IDLE;
            dest_q <= '0;
            src_q  <= '0;
            idx_q  <= '0;
            end_q  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                dest_q <= spike_packet[2*NEURON_ADDR_W-1:NEURON_ADDR_W];
                src_q  <= spike_packet[NEURON_ADDR_W-1:0];
            end
            if (state == FETCH) begin
                idx_q <= row_start;
                end_q <= row_end;
            end else if (state == SEARCH) begin
                idx_q <= idx_q + PTR_W'(1);
            end
        end
    end

    // Runtime-loadable CSR tables, writable only while the block is quiet.
    // NOTE: these small tables are flops and must read as empty rows after reset, so they are reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int n = 0; n <= NUM_NEURONS; n++) row_ptr[n] <= '0;
            for (int c = 0; c < MAX_CONN; c++) src_table[c] <= '0;
        end else if (cfg_ok) begin
            if (!cfg_sel && int'(cfg_addr) <= NUM_NEURONS) begin
                row_ptr[ROW_IDX_W'(cfg_addr)] <= cfg_wdata[PTR_W-1:0];
            end else if (cfg_sel && int'(cfg_addr) < MAX_CONN) begin
                src_table[CONN_IDX_W'(cfg_addr)] <= cfg_wdata;
            end
        end
    end

    // Bitmap banks: set on match, swap and clear the new write bank on a timestep.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bank   <= '0;
            wr_sel <= 1'b0;
        end else if (do_swap) begin
            wr_sel        <= !wr_sel;
            bank[!wr_sel] <= '0;
        end else if (set_bit) begin
            bank[wr_sel][conn_idx] <= 1'b1;
        end
    end

    // Timestep pulses collapse into a single pending swap.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            swap_pending <= 1'b0;
        end else if (timestep) begin
            swap_pending <= 1'b1;
        end else if (do_swap) begin
            swap_pending <= 1'b0;
        end
    end

    // Saturating count of dropped packets.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            drop_count <= '0;
        end else if (drop_inc && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end

    // Registered read port on the read bank.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_spike <= 1'b0;
        end else begin
            rd_spike <= (int'(rd_idx) < MAX_CONN) ? bank[!wr_sel][rd_idx] : 1'b0;
        end
    end

endmodule

// File: tb/tb_spike_input_buffer.sv
// Self-checking bench for spike_input_buffer: fixed vectors from the example
// connection graph, hand-built timestep/reset sequences, and random packets
// scored against a plain array model of the CSR lookup and bitmaps.
module tb_spike_input_buffer;

    localparam int NA = 10;
    localparam int NN = 10;
    localparam int MC = 30;
    localparam int CW = 5;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          spike_valid;
    logic          spike_ready;
    logic [2*NA-1:0] spike_packet;
    logic          cfg_we;
    logic          cfg_sel;
    logic [CW:0]   cfg_addr;
    logic [NA-1:0] cfg_wdata;
    logic          timestep;
    logic [CW-1:0] rd_idx;
    logic          rd_spike;
    logic          busy;
    logic [15:0]   drop_count;

    spike_input_buffer #(
        .NEURON_ADDR_W(NA), .NUM_NEURONS(NN), .MAX_CONN(MC), .CONN_IDX_W(CW)
    ) dut (
        .CLK(CLK), .RESET(RESET), .spike_valid(spike_valid), .spike_ready(spike_ready),
        .spike_packet(spike_packet), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .timestep(timestep),
        .rd_idx(rd_idx), .rd_spike(rd_spike), .busy(busy), .drop_count(drop_count)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_row [NN+1];
    int m_src [MC];
    bit m_bm  [2][MC];
    int m_wr;
    int m_drop;

    function automatic void model_reset();
        foreach (m_row[n]) m_row[n] = 0;
        foreach (m_src[c]) m_src[c] = 0;
        for (int b = 0; b < 2; b++) for (int c = 0; c < MC; c++) m_bm[b][c] = 0;
        m_wr = 0;
        m_drop = 0;
    endfunction

    function automatic void model_swap();
        m_wr = 1 - m_wr;
        for (int c = 0; c < MC; c++) m_bm[m_wr][c] = 0;
    endfunction

    // Cycles from accept (cycle 0) until spike_ready is high again.
    function automatic int model_packet(input int dest, input int src);
        int start, stop, lat, hit;
        hit = -1;
        lat = 2;
        if (dest < NN) begin
            start = m_row[dest];
            stop  = m_row[dest+1];
            if (start < stop) begin
                lat = 2 + (stop - start);
                for (int j = start; j < stop; j++) begin
                    if (m_src[j] == src) begin
                        hit = j;
                        lat = 3 + (j - start);
                        break;
                    end
                end
            end
        end
        if (hit >= 0) m_bm[m_wr][hit] = 1;
        else if (m_drop < 65535) m_drop++;
        return lat;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cfg_write(input bit sel, input int addr, input int data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = (CW+1)'(addr); cfg_wdata = NA'(data);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!spike_ready && n < 50) begin tick(); n++; end
        if (!spike_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic send(input int dest, input int src, output int lat);
        wait_ready();
        spike_valid = 1'b1;
        spike_packet = {NA'(dest), NA'(src)};
        tick();
        spike_valid = 1'b0;
        lat = 1;
        while (!spike_ready && lat < 100) begin tick(); lat++; end
    endtask

    task automatic read_bit(input int idx, output logic v);
        rd_idx = CW'(idx);
        tick();
        v = rd_spike;
    endtask

    // Timestep pulse issued while idle: one swap cycle with ready low.
    task automatic timestep_idle();
        timestep = 1'b1;
        tick();
        timestep = 1'b0;
        check("swap_cycle_ready", spike_ready, 0);
        tick();
        check("after_swap_ready", spike_ready, 1);
        model_swap();
    endtask

    task automatic check_read_bank(input string name);
        logic v;
        for (int c = 0; c < MC; c++) begin
            read_bit(c, v);
            check(name, v, m_bm[1-m_wr][c]);
        end
    endtask

    typedef struct {
        int dest;
        int src;
        int exp_lat;
        int exp_drop;
        int exp_idx;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   row_init [NN+1];
        int   src_init [MC];
        vec_t vecs [9];
        int   lat, prev;
        logic v;

        row_init = '{0, 1, 2, 3, 4, 6, 8, 10, 11, 15, 20};
        src_init = '{1, 2, 3, 0, 5, 6, 0, 1, 2, 3, 4, 5, 6, 8, 7,
                     1, 2, 3, 4, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[0] = '{8, 7, 6, 0, 14};
        vecs[1] = '{4, 9, 4, 1, -1};
        vecs[2] = '{12, 0, 2, 1, -1};
        vecs[3] = '{3, 0, 3, 0, 3};
        vecs[4] = '{3, 0, 3, 0, 3};
        vecs[5] = '{0, 1, 3, 0, 0};
        vecs[6] = '{5, 0, 3, 0, 6};
        vecs[7] = '{9, 4, 6, 0, 18};
        vecs[8] = '{9, 9, 7, 1, -1};

        RESET = 1'b1; spike_valid = 1'b0; spike_packet = '0; cfg_we = 1'b0;
        cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0; timestep = 1'b0; rd_idx = '0;
        tick(); tick();
        check("rst_ready", spike_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_spike", rd_spike, 0);
        check("rst_drop", drop_count, 0);
        RESET = 1'b0;
        model_reset();
        tick();
        check("post_rst_ready", spike_ready, 1);

        for (int n = 0; n <= NN; n++) begin cfg_write(0, n, row_init[n]); m_row[n] = row_init[n]; end
        for (int c = 0; c < MC; c++) begin cfg_write(1, c, src_init[c]); m_src[c] = src_init[c]; end

        // Fixed vectors.
        for (int k = 0; k < 9; k++) begin
            prev = int'(drop_count);
            send(vecs[k].dest, vecs[k].src, lat);
            void'(model_packet(vecs[k].dest, vecs[k].src));
            check($sformatf("vec%0d_latency", k), lat, vecs[k].exp_lat);
            check($sformatf("vec%0d_drop_delta", k), int'(drop_count) - prev, vecs[k].exp_drop);
        end
        timestep_idle();
        for (int k = 0; k < 9; k++) begin
            if (vecs[k].exp_idx >= 0) begin
                read_bit(vecs[k].exp_idx, v);
                check($sformatf("vec%0d_bit", k), v, 1);
            end
        end
        check_read_bank("table_bitmap");

        // Config write while busy is ignored: src_table[14] must stay 7.
        wait_ready();
        spike_valid = 1'b1; spike_packet = {NA'(8), NA'(7)};
        tick();
        spike_valid = 1'b0;
        cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = (CW+1)'(14); cfg_wdata = NA'(9);
        tick();
        cfg_we = 1'b0;
        wait_ready();
        void'(model_packet(8, 7));
        check("busy_cfg_drop", drop_count, m_drop);
        send(8, 7, lat);
        void'(model_packet(8, 7));
        check("busy_cfg_lat", lat, 6);
        check("busy_cfg_drop2", drop_count, m_drop);

        // Timestep pulse arrives in cycle 2 of an in-flight search.
        wait_ready();
        spike_valid = 1'b1; spike_packet = {NA'(9), NA'(7)};
        tick();
        spike_valid = 1'b0;
        tick();
        timestep = 1'b1;
        check("inflight_busy_c2", busy, 1);
        tick();
        timestep = 1'b0;
        for (int c = 3; c <= 6; c++) begin
            check($sformatf("inflight_busy_c%0d", c), busy, 1);
            tick();
        end
        check("inflight_swap_ready", spike_ready, 0);
        check("inflight_swap_busy", busy, 1);
        tick();
        check("inflight_ready", spike_ready, 1);
        check("inflight_idle_busy", busy, 0);
        void'(model_packet(9, 7));
        model_swap();
        read_bit(19, v);
        check("inflight_bit19", v, m_bm[1-m_wr][19]);
        timestep = 1'b1;
        tick();
        timestep = 1'b0;
        read_bit(19, v);
        check("swap_cycle_read_old_bank", v, m_bm[1-m_wr][19]);
        model_swap();
        read_bit(19, v);
        check("second_swap_bit19", v, m_bm[1-m_wr][19]);

        // Randomised packets against the model.
        for (int r = 0; r < 40; r++) begin
            int d, s, mlat;
            if ($urandom_range(0, 4) == 0) timestep_idle();
            d = int'($urandom_range(0, 11));
            s = int'($urandom_range(0, 9));
            send(d, s, lat);
            mlat = model_packet(d, s);
            check($sformatf("rand%0d_lat d=%0d s=%0d", r, d, s), lat, mlat);
            check($sformatf("rand%0d_drop", r), drop_count, m_drop);
        end
        timestep_idle();
        check_read_bank("rand_bitmap");

        // Reset asserted in cycle 3 of a search.
        wait_ready();
        spike_valid = 1'b1; spike_packet = {NA'(9), NA'(9)};
        tick();
        spike_valid = 1'b0;
        tick();
        tick();
        RESET = 1'b1;
        #1;
        check("midrst_ready", spike_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_drop", drop_count, 0);
        check("midrst_rd_spike", rd_spike, 0);
        tick();
        RESET = 1'b0;
        model_reset();
        tick();
        check("midrst_release_ready", spike_ready, 1);
        check_read_bank("midrst_bitmap");
        send(0, 0, lat);
        void'(model_packet(0, 0));
        check("midrst_empty_lat", lat, 2);
        check("midrst_empty_drop", drop_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
